// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD capture path.
// The LCD_RECEIVER_CRC_EN macro is consumed by lcd_receiver, not by this package.
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VBLANK = 2'd1,
        ST_LINE   = 2'd2,
        ST_HBLANK = 2'd3
    } rx_state_e;

    localparam int H_ACTIVE_DEF = 800;
    localparam int V_ACTIVE_DEF = 480;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/lcd_crc16.sv
// CRC-16/CCITT-FALSE register that folds one 24-bit RGB word (R, G, B; MSB first) per enabled clock.
// Instantiated by lcd_receiver only when LCD_RECEIVER_CRC_EN is defined.
module lcd_crc16
    import lcd_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [15:0] init_i,
    input  logic        en_i,
    input  logic        clr_i,
    input  logic [23:0] data_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;
    logic        fb;

    always_comb begin
        crc_d = crc_q;
        fb    = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            fb    = crc_d[15] ^ data_i[i];
            crc_d = {crc_d[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
        end
    end

    // Clear has priority so a frame boundary never absorbs a stray pixel.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            crc_q <= CRC_INIT;
        end else if (clr_i) begin
            crc_q <= init_i;
        end else if (en_i) begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/lcd_receiver.sv
// Parallel RGB LCD capture: pixel coordinates, frame geometry, sticky timing errors and lock.
// Optional per-frame CRC over captured pixels when LCD_RECEIVER_CRC_EN is defined.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_HUNT   | after reset; ignore everything until a vs_n falling edge
//   ST_VBLANK | inside a frame, before the first line or between frames
//   ST_LINE   | DE high, capturing pixels of the current line
//   ST_HBLANK | DE low between lines of a frame
module lcd_receiver
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic        tick_i,
    input  logic        hs_n_i,
    input  logic        vs_n_i,
    input  logic        data_enable_i,
    input  logic [7:0]  red_i,
    input  logic [7:0]  green_i,
    input  logic [7:0]  blue_i,
    input  logic        err_clear_i,
    output logic        pixel_valid_o,
    output logic [9:0]  pixel_x_o,
    output logic [9:0]  pixel_y_o,
    output logic [7:0]  pixel_red_o,
    output logic [7:0]  pixel_green_o,
    output logic [7:0]  pixel_blue_o,
    output logic        frame_done_o,
    output logic [9:0]  frame_width_o,
    output logic [9:0]  frame_height_o,
    output logic        locked_o,
    output logic        err_width_o,
    output logic        err_height_o,
    output logic        err_sync_o,
    output logic [15:0] frame_crc_o
);

    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

    // Input sample stage and the previous sample used for edge detection.
    logic        smp_vld_q;
    logic        s_hs_q, s_vs_q, s_de_q;
    logic [23:0] s_rgb_q;
    logic        p_vs_q, p_de_q;

    rx_state_e   state_q;
    logic [9:0]  x_cnt_q;
    logic [9:0]  y_q;
    logic [9:0]  last_len_q;
    logic        frame_err_q;
    logic [3:0]  good_q;

    logic        pixel_valid_q;
    logic [9:0]  pixel_x_q, pixel_y_q;
    logic [23:0] pixel_rgb_q;
    logic        frame_done_q;
    logic [9:0]  frame_width_q, frame_height_q;
    logic        locked_q;
    logic        err_width_q, err_height_q, err_sync_q;

    logic        vs_fall, de_rise, sync_viol;
    logic        in_frame, frame_end, truncated, line_end;
    logic        pix_take;
    logic [9:0]  pix_x;
    logic [9:0]  fe_width;
    logic        fe_h_err, fe_bad;
    logic [3:0]  good_d;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            smp_vld_q <= 1'b0;
            s_hs_q    <= 1'b1;
            s_vs_q    <= 1'b1;
            s_de_q    <= 1'b0;
            s_rgb_q   <= '0;
            p_vs_q    <= 1'b1;
            p_de_q    <= 1'b0;
        end else begin
            smp_vld_q <= tick_i;
            if (tick_i) begin
                p_vs_q  <= s_vs_q;
                p_de_q  <= s_de_q;
                s_hs_q  <= hs_n_i;
                s_vs_q  <= vs_n_i;
                s_de_q  <= data_enable_i;
                s_rgb_q <= {red_i, green_i, blue_i};
            end
        end
    end

    // Event decode for the sample registered on the previous tick; vs_n fall outranks DE activity.
    always_comb begin
        vs_fall   = smp_vld_q & p_vs_q & ~s_vs_q;
        de_rise   = smp_vld_q & ~p_de_q & s_de_q;
        sync_viol = smp_vld_q & s_de_q & (~s_hs_q | ~s_vs_q);
        in_frame  = (state_q != ST_HUNT);
        frame_end = vs_fall & in_frame;
        truncated = frame_end & (state_q == ST_LINE);
        line_end  = smp_vld_q & (state_q == ST_LINE) & ~s_de_q & ~vs_fall;

        pix_take = 1'b0;
        pix_x    = '0;
        case (state_q)
            ST_VBLANK, ST_HBLANK: pix_take = de_rise & ~vs_fall;
            ST_LINE: begin
                pix_take = smp_vld_q & s_de_q & ~vs_fall;
                pix_x    = x_cnt_q;
            end
            default: pix_take = 1'b0;
        endcase

        fe_width = truncated ? x_cnt_q : last_len_q;
        fe_h_err = (y_q != V_ACT);
        fe_bad   = frame_err_q | sync_viol | truncated | fe_h_err;
        if (fe_bad) begin
            good_d = '0;
        end else if (good_q == LOCK_N) begin
            good_d = good_q;
        end else begin
            good_d = good_q + 4'd1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q        <= ST_HUNT;
            x_cnt_q        <= '0;
            y_q            <= '0;
            last_len_q     <= '0;
            frame_err_q    <= 1'b0;
            good_q         <= '0;
            pixel_valid_q  <= 1'b0;
            pixel_x_q      <= '0;
            pixel_y_q      <= '0;
            pixel_rgb_q    <= '0;
            frame_done_q   <= 1'b0;
            frame_width_q  <= '0;
            frame_height_q <= '0;
            locked_q       <= 1'b0;
            err_width_q    <= 1'b0;
            err_height_q   <= 1'b0;
            err_sync_q     <= 1'b0;
        end else begin
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;

            // Later assignments in this block win, so a same-cycle new error keeps its flag set.
            if (err_clear_i) begin
                err_width_q  <= 1'b0;
                err_height_q <= 1'b0;
                err_sync_q   <= 1'b0;
            end

            if (sync_viol) begin
                err_sync_q  <= 1'b1;
                frame_err_q <= 1'b1;
            end

            if (pix_take) begin
                pixel_valid_q <= 1'b1;
                pixel_x_q     <= pix_x;
                pixel_y_q     <= y_q;
                pixel_rgb_q   <= s_rgb_q;
                x_cnt_q       <= (state_q == ST_LINE) ? sat_inc(x_cnt_q) : 10'd1;
                state_q       <= ST_LINE;
            end

            if (line_end) begin
                state_q    <= ST_HBLANK;
                last_len_q <= x_cnt_q;
                y_q        <= sat_inc(y_q);
                if (x_cnt_q != H_ACT) begin
                    err_width_q <= 1'b1;
                    frame_err_q <= 1'b1;
                end
            end

            // Any vs_n fall starts a fresh frame; only one inside a frame reports the old one.
            if (vs_fall) begin
                state_q     <= ST_VBLANK;
                x_cnt_q     <= '0;
                y_q         <= '0;
                last_len_q  <= '0;
                frame_err_q <= 1'b0;
            end

            if (frame_end) begin
                frame_done_q   <= 1'b1;
                frame_width_q  <= fe_width;
                frame_height_q <= y_q;
                good_q         <= good_d;
                locked_q       <= (good_d == LOCK_N);
                if (truncated) begin
                    err_width_q <= 1'b1;
                end
                if (fe_h_err) begin
                    err_height_q <= 1'b1;
                end
            end
        end
    end

    assign pixel_valid_o  = pixel_valid_q;
    assign pixel_x_o      = pixel_x_q;
    assign pixel_y_o      = pixel_y_q;
    assign pixel_red_o    = pixel_rgb_q[23:16];
    assign pixel_green_o  = pixel_rgb_q[15:8];
    assign pixel_blue_o   = pixel_rgb_q[7:0];
    assign frame_done_o   = frame_done_q;
    assign frame_width_o  = frame_width_q;
    assign frame_height_o = frame_height_q;
    assign locked_o       = locked_q;
    assign err_width_o    = err_width_q;
    assign err_height_o   = err_height_q;
    assign err_sync_o     = err_sync_q;

`ifdef LCD_RECEIVER_CRC_EN
    logic [15:0] crc_run;
    logic [15:0] frame_crc_q;

    lcd_crc16 u_crc (
        .clk_i   (clock_i),
        .rst_n_i (reset_n_i),
        .init_i  (CRC_INIT),
        .en_i    (pix_take),
        .clr_i   (vs_fall),
        .data_i  (s_rgb_q),
        .crc_o   (crc_run)
    );

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            frame_crc_q <= '0;
        end else if (frame_end) begin
            frame_crc_q <= crc_run;
        end
    end

    assign frame_crc_o = frame_crc_q;
`else
    assign frame_crc_o = 16'h0000;
`endif

endmodule

// File: tb/tb_lcd_receiver.sv
// Scoreboard bench for lcd_receiver on a reduced 12x8 geometry with tick every other clock.
// Expected frame_crc follows LCD_RECEIVER_CRC_EN.
module tb_lcd_receiver;
    localparam int H  = 12;
    localparam int V  = 8;
    localparam int LK = 2;

`ifdef LCD_RECEIVER_CRC_EN
    localparam logic [15:0] EXP_CRC = 16'h29B1;
`else
    localparam logic [15:0] EXP_CRC = 16'h0000;
`endif

    logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0;
    logic hs_n = 1'b1, vs_n = 1'b1, de = 1'b0, err_clear = 1'b0;
    logic [7:0] r = '0, g = '0, b = '0;

    logic        pixel_valid, frame_done, locked, err_width, err_height, err_sync;
    logic [9:0]  pixel_x, pixel_y, frame_width, frame_height;
    logic [7:0]  pixel_red, pixel_green, pixel_blue;
    logic [15:0] frame_crc;
    logic [85:0] all_outs;

    lcd_receiver #(.H_ACTIVE(H), .V_ACTIVE(V), .LOCK_FRAMES(LK)) dut (
        .clock_i(clk), .reset_n_i(rst_n), .tick_i(tick),
        .hs_n_i(hs_n), .vs_n_i(vs_n), .data_enable_i(de),
        .red_i(r), .green_i(g), .blue_i(b), .err_clear_i(err_clear),
        .pixel_valid_o(pixel_valid), .pixel_x_o(pixel_x), .pixel_y_o(pixel_y),
        .pixel_red_o(pixel_red), .pixel_green_o(pixel_green), .pixel_blue_o(pixel_blue),
        .frame_done_o(frame_done), .frame_width_o(frame_width), .frame_height_o(frame_height),
        .locked_o(locked), .err_width_o(err_width), .err_height_o(err_height),
        .err_sync_o(err_sync), .frame_crc_o(frame_crc)
    );

    assign all_outs = {pixel_valid, pixel_x, pixel_y, pixel_red, pixel_green, pixel_blue,
                       frame_done, frame_width, frame_height, locked,
                       err_width, err_height, err_sync, frame_crc};

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [23:0] rgb;
    } pix_t;

    typedef struct packed {
        logic [9:0]  w;
        logic [9:0]  h;
        logic        lk;
        logic        ew;
        logic        eh;
        logic        chk;
        logic [15:0] crc;
    } frm_t;

    pix_t exp_pix[$];
    frm_t exp_frm[$];
    int   total = 0;
    int   bad   = 0;
    logic [7:0]  fid = 8'h10;
    bit          use_tab = 1'b0;
    logic [23:0] tab [3];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One LCD sample: inputs held with tick high for one clock, then one idle clock.
    task automatic smp(input logic [2:0] hvd, input logic [23:0] rgb);
        @(negedge clk);
        {hs_n, vs_n, de} = hvd;
        {r, g, b} = rgb;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic line(input int y, input int n, input bit expect_pix, input bit hblank);
        pix_t p;
        logic [23:0] c;
        for (int x = 0; x < n; x++) begin
            c = use_tab ? tab[x] : {8'(x), 8'(y), fid};
            if (expect_pix) begin
                p.x = 10'(x);
                p.y = 10'(y);
                p.rgb = c;
                exp_pix.push_back(p);
            end
            smp(3'b111, c);
        end
        if (hblank) begin
            smp(3'b110, 24'h0);
            smp(3'b010, 24'h0);
            smp(3'b010, 24'h0);
            smp(3'b110, 24'h0);
        end
    endtask

    task automatic vsync();
        smp(3'b000, 24'h0);
        smp(3'b000, 24'h0);
        smp(3'b110, 24'h0);
        smp(3'b110, 24'h0);
    endtask

    task automatic frame(input bit expect_pix, input int short_y, input int short_len);
        for (int y = 0; y < V; y++) begin
            line(y, (y == short_y) ? short_len : H, expect_pix, 1'b1);
        end
        fid++;
    endtask

    task automatic exp_frame(input int w, input int h, input int lk, input int ew,
                             input int eh, input int chk, input logic [15:0] crc);
        frm_t f;
        f.w = 10'(w);
        f.h = 10'(h);
        f.lk = (lk != 0);
        f.ew = (ew != 0);
        f.eh = (eh != 0);
        f.chk = (chk != 0);
        f.crc = crc;
        exp_frm.push_back(f);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        pix_t p;
        frm_t f;
        if (rst_n) begin
            if (pixel_valid) begin
                if (exp_pix.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pix_unexpected: got x=%0d y=%0d want no pixel", pixel_x, pixel_y);
                end else begin
                    p = exp_pix.pop_front();
                    check("pix_x", 128'(pixel_x), 128'(p.x));
                    check("pix_y", 128'(pixel_y), 128'(p.y));
                    check("pix_rgb", 128'({pixel_red, pixel_green, pixel_blue}), 128'(p.rgb));
                end
            end
            if (frame_done) begin
                if (exp_frm.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL fd_unexpected: got w=%0d h=%0d want no frame_done",
                             frame_width, frame_height);
                end else begin
                    f = exp_frm.pop_front();
                    check("fd_width", 128'(frame_width), 128'(f.w));
                    check("fd_height", 128'(frame_height), 128'(f.h));
                    check("fd_locked", 128'(locked), 128'(f.lk));
                    check("fd_err_width", 128'(err_width), 128'(f.ew));
                    check("fd_err_height", 128'(err_height), 128'(f.eh));
                    if (f.chk) check("fd_crc", 128'(frame_crc), 128'(f.crc));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0] = 24'h313233;
        tab[1] = 24'h343536;
        tab[2] = 24'h373839;

        repeat (2) @(negedge clk);
        check("reset_outs", 128'(all_outs), 128'(0));
        rst_n = 1'b1;

        // Sync violations while hunting
        smp(3'b011, 24'h0);
        @(negedge clk);
        check("sync_hs_set", 128'(err_sync), 128'(1));
        pulse_clear();
        check("sync_clear", 128'(err_sync), 128'(0));
        @(negedge clk);
        {hs_n, vs_n, de} = 3'b011;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("sync_clear_vs_new", 128'(err_sync), 128'(1));
        pulse_clear();
        check("sync_clear2", 128'(err_sync), 128'(0));
        smp(3'b101, 24'h0);
        @(negedge clk);
        check("sync_vs_set", 128'(err_sync), 128'(1));
        check("sync_no_werr", 128'({err_width, err_height}), 128'(0));
        smp(3'b110, 24'h0);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset2_outs", 128'(all_outs), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Clean frames: lock after the second
        repeat (3) smp(3'b110, 24'h0);
        vsync();
        frame(1'b1, -1, 0);
        exp_frame(H, V, 0, 0, 0, 0, 16'h0);
        vsync();
        frame(1'b1, -1, 0);
        exp_frame(H, V, 1, 0, 0, 0, 16'h0);
        vsync();
        frame(1'b1, -1, 0);
        exp_frame(H, V, 1, 0, 0, 0, 16'h0);
        vsync();

        // Short line 3, then relock with sticky err_width
        frame(1'b1, 3, H - 1);
        exp_frame(H, V, 0, 1, 0, 0, 16'h0);
        vsync();
        frame(1'b1, -1, 0);
        exp_frame(H, V, 0, 1, 0, 0, 16'h0);
        vsync();
        frame(1'b1, -1, 0);
        exp_frame(H, V, 1, 1, 0, 0, 16'h0);
        vsync();
        @(negedge clk);
        check("ew_sticky", 128'(err_width), 128'(1));
        pulse_clear();
        check("ew_cleared", 128'(err_width), 128'(0));

        // Early vsync in line 5 after 7 pixels
        for (int y = 0; y < 5; y++) line(y, H, 1'b1, 1'b1);
        line(5, 7, 1'b1, 1'b0);
        fid++;
        exp_frame(7, 5, 0, 1, 1, 0, 16'h0);
        vsync();
        pulse_clear();
        check("errs_cleared", 128'({err_width, err_height, err_sync}), 128'(0));

        // One 3-pixel line carrying "123456789"
        use_tab = 1'b1;
        line(0, 3, 1'b1, 1'b1);
        use_tab = 1'b0;
        exp_frame(3, 1, 0, 1, 1, 1, EXP_CRC);
        vsync();
        pulse_clear();

        // Reset mid-frame, resync on the next vsync
        for (int y = 0; y < 4; y++) line(y, H, 1'b1, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_mid_outs", 128'(all_outs), 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int y = 4; y < V; y++) line(y, H, 1'b0, 1'b1);
        vsync();
        frame(1'b1, -1, 0);
        exp_frame(H, V, 0, 0, 0, 0, 16'h0);
        vsync();
        repeat (6) @(negedge clk);

        check("pix_left", 128'(exp_pix.size()), 128'(0));
        check("frm_left", 128'(exp_frm.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_receiver.md
# lcd_receiver

Capture-side counterpart of the LCD timing generator. It samples a parallel RGB LCD stream (pixel-clock enable, hs_n, vs_n, data_enable, 8-bit R/G/B), recovers pixel coordinates and measures frame geometry. It flags timing violations and reports lock once consecutive frames match the expected geometry. It sits on the GPIO loopback / test-capture path and checks the LCD output of the main design in hardware and in simulation.

## Interface
- H_ACTIVE, 800, expected active pixels per line
- V_ACTIVE, 480, expected active lines per frame
- LOCK_FRAMES, 2, consecutive clean frames required for lock (1..15)
- clock  input  1  system clock (50 MHz)
- reset_n  input  1  asynchronous, active-low reset
- tick  input  1  pixel-clock enable; LCD inputs are sampled only on clocks where tick=1
- hs_n, vs_n  input  1 each  active-low syncs
- data_enable  input  1  active-video qualifier
- red, green, blue  input  8 each  pixel data
- err_clear  input  1  clears sticky error flags
- pixel_valid  output  1  one-clock pulse per captured active pixel
- pixel_x  output  10  column of current pixel
- pixel_y  output  10  row of current pixel
- pixel_red, pixel_green, pixel_blue  output  8 each  captured pixel data
- frame_done  output  1  one-clock pulse at end of frame
- frame_width, frame_height  output  10 each  measured geometry, latched at frame_done
- locked  output  1  geometry stable
- err_width, err_height, err_sync  output  1 each  sticky error flags
- frame_crc  output  16  per-frame CRC (see Configuration)

## Operation
- On tick, an input register stage captures hs_n, vs_n, data_enable and RGB. Edges are detected against the previous sample.
- States:
  - HUNT (reset): wait for a vs_n falling edge; go to VBLANK with no frame_done.
  - VBLANK: go to LINE on a DE rise.
  - LINE: go to HBLANK on a DE fall.
  - HBLANK: a DE rise returns to LINE; a vs_n fall ends the frame and goes to VBLANK.
- In LINE, every sampled pixel emits pixel_valid with pixel_x and pixel_y.
  - x clears on a DE rise and increments per pixel, saturating at 1023.
  - y clears at frame end and increments on each DE fall.
- Each DE fall compares the line length against H_ACTIVE; a mismatch sets err_width.
- Frame end (vs_n fall in any non-HUNT state) does the following:
  - pulse frame_done;
  - latch frame_width (last line length) and frame_height (line count);
  - set err_height if the line count ≠ V_ACTIVE.
- A vs_n fall while in LINE is a truncated line: set err_width, then run frame end.
- err_sync sets when DE=1 is sampled while hs_n=0 or vs_n=0.
- Lock:
  - A frame with no error raised during it increments the good counter (saturating at LOCK_FRAMES). `locked` asserts when the counter equals LOCK_FRAMES.
  - Any error during a frame clears the counter and `locked` at frame end.
- err_clear clears all three flags on the next clock. A simultaneous new error wins; the flag stays set.

## Timing
- Reset values: state HUNT; all outputs 0 (pixel_x, pixel_y, widths, heights, crc, flags, locked, pulses).
- Latency: a pixel sampled on a tick clock at edge N produces pixel_valid and data valid in the cycle after edge N+1. The pulse lasts exactly one clock, regardless of tick rate.
- frame_done and the latched frame_width / frame_height / frame_crc appear together, one clock after the vs_n-fall sample is registered. `locked` updates in the same cycle.
- Reset asserted mid-frame: outputs clear immediately. After release, the partial frame is ignored until the next vs_n fall.
- tick=0: no state change, no pulses.

## Configuration
- LCD_RECEIVER_CRC_EN defined:
  - CRC-16/CCITT-FALSE (polynomial 0x1021, init 0xFFFF, no reflection, no xorout) over every pixel_valid pixel.
  - Each pixel contributes bytes R, G, B, MSB first.
  - The CRC reinitialises at frame end, and the final value is latched into frame_crc at frame_done.
- Undefined: frame_crc is tied to 16'h0000 and no CRC logic is synthesised. The port always exists.

## Structure
- Shared package lcd_pkg holds:
  - the receiver state enum (HUNT, VBLANK, LINE, HBLANK);
  - default geometry constants 800/480;
  - CRC_POLY 16'h1021 and CRC_INIT 16'hFFFF.
- Sub-module lcd_crc16: a 24-bit-per-step CRC update register with init, enable and clear inputs. It is instantiated only under LCD_RECEIVER_CRC_EN.

## Test plan
1. **Clean loopback.** Drive from the LCD timing generator at 800×480 for 3 frames.
   - frame_done per frame, width 800, height 480.
   - locked=1 after the 2nd frame_done; no errors.
2. **Short line.** Frame 2 line 10 has 799 pixels.
   - err_width=1; locked drops at that frame_done.
   - Relocks after 2 further clean frames, with err_width still 1 until err_clear.
3. **Early vsync.** vs_n falls in line 5 at x=100.
   - frame_done with frame_width=100, frame_height=5; err_width=1, err_height=1.
4. **Sync violation.** DE=1 while vs_n=0.
   - err_sync=1.
   - err_clear pulse clears it next clock; err_clear coinciding with a repeat violation keeps it at 1.
5. **Reset mid-frame.** reset_n low at line 200.
   - All outputs 0 asynchronously.
   - No pixel_valid until after the next vs_n fall and DE rise; first pixel_x=0, pixel_y=0.
6. **CRC check (LCD_RECEIVER_CRC_EN, H_ACTIVE=3, V_ACTIVE=1).** Pixels 0x313233, 0x343536, 0x373839.
   - frame_crc=16'h29B1.
   - With the macro undefined, frame_crc=16'h0000.
